// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and state encoding for the 3x3 Gaussian convolution engine
package conv_pkg;
  localparam int ACC_W = 12;
  localparam int KSHIFT = 4;
  localparam int ROUND_BIAS = 8;
  localparam logic [2:0] KW [0:8] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1};
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/conv_pixel_ram.sv
// conv_pixel_ram: single-port pixel RAM, synchronous read with one cycle of latency
module conv_pixel_ram #(
  parameter int DEPTH = 65536,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:DEPTH-1];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/convolution_top.sv
// convolution_top: 3x3 Gaussian blur over a RAM-held frame, 11 cycles per output pixel
// Define CONV_ROUND_EN to round half up instead of truncating.
module convolution_top
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = 256,
  parameter int IMAGE_HEIGHT = 256,
  localparam int ADDR_W = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        pixel_in,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic              pixel_we,
  output logic [7:0]        pixel_out,
  output logic [ADDR_W-1:0] output_addr,
  output logic              output_we,
  output logic              done
);
`ifdef CONV_ROUND_EN
  localparam int BIAS = ROUND_BIAS;
`else
  localparam int BIAS = 0;
`endif
  localparam int N = IMAGE_WIDTH * IMAGE_HEIGHT;
  state_t state;
  logic [3:0] c, col, tap_i;
  logic [ADDR_W-1:0] x, y, cur, tap_addr, ram_addr;
  logic [7:0] rdata, res;
  logic [ACC_W-1:0] acc, term, acc_nx;
  logic busy, up, down, left, right, inb, tap_v;
  conv_pixel_ram #(.DEPTH(N), .AW(ADDR_W)) u_ram (
    .clk(clk),
    .we(pixel_we && !busy),
    .addr(ram_addr),
    .wdata(pixel_in),
    .rdata(rdata)
  );
  always_comb begin
    busy = state == BUSY;
    col = c - (c >= 4'd6 ? 4'd6 : c >= 4'd3 ? 4'd3 : 4'd0);
    up = c < 4'd3;
    down = c >= 4'd6;
    left = col == 4'd0;
    right = col == 4'd2;
    inb = c < 4'd9 && !(up && y == '0) && !(down && y == ADDR_W'(IMAGE_HEIGHT - 1))
          && !(left && x == '0) && !(right && x == ADDR_W'(IMAGE_WIDTH - 1));
    tap_addr = cur + (down ? ADDR_W'(IMAGE_WIDTH) : '0) - (up ? ADDR_W'(IMAGE_WIDTH) : '0)
               + ADDR_W'(right) - ADDR_W'(left);
    ram_addr = busy ? tap_addr : pixel_addr;
    term = tap_v ? ACC_W'(rdata) * ACC_W'(KW[tap_i]) : '0;
    acc_nx = acc + term;
    res = 8'((acc_nx + ACC_W'(BIAS)) >> KSHIFT);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      c <= '0;
      x <= '0;
      y <= '0;
      cur <= '0;
      acc <= '0;
      tap_v <= 1'b0;
      tap_i <= '0;
      pixel_out <= '0;
      output_addr <= '0;
      output_we <= 1'b0;
      done <= 1'b0;
    end else begin
      tap_v <= busy && inb;
      tap_i <= c;
      output_we <= busy && c == 4'd9;
      if (!busy) begin
        if (start) begin
          state <= BUSY;
          done <= 1'b0;
          c <= '0;
          x <= '0;
          y <= '0;
          cur <= '0;
          acc <= '0;
        end
      end else begin
        c <= c == 4'd10 ? 4'd0 : c + 4'd1;
        acc <= c == 4'd10 ? '0 : acc_nx;
        // result uses acc_nx so the last tap lands in the same edge that raises the strobe
        if (c == 4'd9) begin
          pixel_out <= res;
          output_addr <= cur;
        end
        if (c == 4'd10) begin
          cur <= cur + 1'b1;
          x <= x == ADDR_W'(IMAGE_WIDTH - 1) ? '0 : x + 1'b1;
          y <= x == ADDR_W'(IMAGE_WIDTH - 1) ? y + 1'b1 : y;
          if (cur == ADDR_W'(N - 1)) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_convolution_top.sv
// tb_convolution_top: randomized self-checking bench for convolution_top on a 4x4 frame
module tb_convolution_top;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int AW = 4;
  logic clk = 0, rst = 0, start = 0, pixel_we = 0;
  logic [7:0] pixel_in = 0;
  logic [AW-1:0] pixel_addr = 0;
  logic [7:0] pixel_out;
  logic [AW-1:0] output_addr;
  logic output_we, done;
  int checks = 0, fails = 0;
  int img [N];
  int got [N];
  int lat;
  convolution_top #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in), .pixel_addr(pixel_addr),
    .pixel_we(pixel_we), .pixel_out(pixel_out), .output_addr(output_addr),
    .output_we(output_we), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int model(input int a);
    int px = a % W, py = a / W, s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (px + dx >= 0 && px + dx < W && py + dy >= 0 && py + dy < H)
          s += img[(py + dy) * W + px + dx] * (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
`ifdef CONV_ROUND_EN
    return (s + 8) / 16;
`else
    return s / 16;
`endif
  endfunction
  task automatic load();
    for (int i = 0; i < N; i++) begin
      pixel_addr = AW'(i);
      pixel_in = 8'(img[i]);
      pixel_we = 1;
      @(negedge clk);
    end
    pixel_we = 0;
  endtask
  task automatic run_frame(input int disturb_at, output int latency);
    int n, strobes, nxt, lp, la;
    start = 1;
    @(negedge clk);
    start = 0;
    check("done_clr", done, 0);
    n = 1; strobes = 0; nxt = 0; lp = 0; la = 0;
    while (!done && n < 2000) begin
      if (n == disturb_at) begin
        start = 1; pixel_we = 1; pixel_addr = 5; pixel_in = 8'hA5;
      end else if (n == disturb_at + 1) begin
        start = 0; pixel_we = 0;
      end
      if (output_we) begin
        check("order", output_addr, nxt);
        check("pix", pixel_out, model(nxt));
        got[nxt % N] = pixel_out;
        lp = pixel_out; la = output_addr;
        nxt++; strobes++;
      end else if (strobes > 0) begin
        check("hold_pix", pixel_out, lp);
        check("hold_addr", output_addr, la);
      end
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    check("strobes", strobes, N);
    latency = n - 1;
    repeat (3) @(negedge clk);
    check("done_hold", done, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_pix", pixel_out, 0);
    check("rst_addr", output_addr, 0);
    check("rst_we", output_we, 0);
    check("rst_done", done, 0);
    rst = 1;
    @(negedge clk);
    foreach (img[i]) img[i] = 16;
    load();
    run_frame(-10, lat);
    check("latency", lat, 11 * N);
    check("c16_corner", got[0], 9);
    check("c16_edge", got[1], 12);
    check("c16_inner", got[5], 16);
    foreach (img[i]) img[i] = 255;
    load();
    run_frame(40, lat);
    check("c255_corner", got[15], 143);
    check("c255_edge", got[4], 191);
    check("c255_inner", got[10], 255);
    foreach (img[i]) img[i] = 0;
    img[5] = 8;
    load();
    run_frame(-10, lat);
    check("imp_center", got[5], 2);
    check("imp_edge", got[9], 1);
    check("imp_zero", got[15], 0);
`ifdef CONV_ROUND_EN
    check("imp_diag", got[10], 1);
`else
    check("imp_diag", got[10], 0);
`endif
    for (int r = 0; r < 3; r++) begin
      foreach (img[i]) img[i] = int'($urandom_range(0, 255));
      load();
      run_frame(-10, lat);
    end
    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    load();
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (60) @(negedge clk);
    rst = 0;
    #1;
    check("abort_pix", pixel_out, 0);
    check("abort_addr", output_addr, 0);
    check("abort_we", output_we, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    run_frame(-10, lat);
    check("abort_latency", lat, 11 * N);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
